// File: rtl/fft16_twiddle_seq.sv
// fft16_twiddle_seq: butterfly address and twiddle
// sequencer for a 16-point radix-2 DIF FFT.
module fft16_twiddle_seq #(
  parameter int ADDR_W = 4,
  parameter int TW_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inverse,
  input  logic              ready,
  output logic              valid,
  output logic [1:0]        stage,
  output logic [ADDR_W-1:0] top_addr,
  output logic [ADDR_W-1:0] bot_addr,
  output logic [TW_W-1:0]   tw_re,
  output logic [TW_W-1:0]   tw_im,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0] s_q, s_d;
  logic [2:0] b_q, b_d;
  logic       inv_q, inv_d;
  logic       load;

  logic valid_q, valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [1:0]        stage_q;
  logic [ADDR_W-1:0] top_q, top_d;
  logic [ADDR_W-1:0] bot_q, bot_d;
  logic [TW_W-1:0]   re_q, re_d;
  logic [TW_W-1:0]   im_q, im_d;

  logic [3:0] span, bx, j, k4;
  logic [2:0] k;
  logic [TW_W-1:0] sin_c;

  // next-state, counter advance and descriptor load
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    inv_d   = inv_q;
    load    = 1'b0;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = 2'd0;
          b_d     = 3'd0;
          inv_d   = inverse;
          load    = 1'b1;
          valid_d = 1'b1;
        end
      end
      RUN: begin
        if (ready) begin
          if (s_q == 2'd3 && b_q == 3'd7) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            load = 1'b1;
            if (b_q == 3'd7) begin
              b_d = 3'd0;
              s_d = s_q + 2'd1;
            end else begin
              b_d = b_q + 3'd1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // descriptor for the counters about to be loaded
  always_comb begin
    span  = 4'd8 >> s_d;
    bx    = {1'b0, b_d};
    j     = bx & (span - 4'd1);
    k4    = j << s_d;
    k     = k4[2:0];
    top_d = ADDR_W'(((bx - j) << 1) + j);
    bot_d = top_d + ADDR_W'(span);
    re_d  = '0;
    sin_c = '0;
    unique case (k)
      3'd0: begin re_d = 8'h7F; sin_c = 8'h00; end
      3'd1: begin re_d = 8'h76; sin_c = 8'h31; end
      3'd2: begin re_d = 8'h5A; sin_c = 8'h5A; end
      3'd3: begin re_d = 8'h31; sin_c = 8'h76; end
      3'd4: begin re_d = 8'h00; sin_c = 8'h7F; end
      3'd5: begin re_d = 8'hCF; sin_c = 8'h76; end
      3'd6: begin re_d = 8'hA6; sin_c = 8'h5A; end
      3'd7: begin re_d = 8'h8A; sin_c = 8'h31; end
      default: begin re_d = '0; sin_c = '0; end
    endcase
    im_d = inv_d ? sin_c : TW_W'(~sin_c + 1'b1);
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      inv_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stage_q <= '0;
      top_q   <= '0;
      bot_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      inv_q   <= inv_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (load) begin
        stage_q <= s_d;
        top_q   <= top_d;
        bot_q   <= bot_d;
        re_q    <= re_d;
        im_q    <= im_d;
      end
    end
  end

  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign stage    = stage_q;
  assign top_addr = top_q;
  assign bot_addr = bot_q;
  assign tw_re    = re_q;
  assign tw_im    = im_q;

endmodule

// File: tb/tb_fft16_twiddle_seq.sv
// tb_fft16_twiddle_seq: directed vectors for the
// 16-point FFT butterfly/twiddle sequencer.
module tb_fft16_twiddle_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       inverse = 1'b0;
  logic       ready = 1'b0;
  logic       valid;
  logic [1:0] stage;
  logic [3:0] top_addr, bot_addr;
  logic [7:0] tw_re, tw_im;
  logic       busy, done;

  fft16_twiddle_seq #(.ADDR_W(4), .TW_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .inverse(inverse), .ready(ready),
    .valid(valid), .stage(stage),
    .top_addr(top_addr), .bot_addr(bot_addr),
    .tw_re(tw_re), .tw_im(tw_im),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         beat;
    logic [1:0] st;
    logic [3:0] top;
    logic [3:0] bot;
    logic [7:0] re;
    logic [7:0] im;
  } vec_t;

  vec_t fwd[8];
  vec_t inv_v[2];
  logic [7:0] cos_rom[8];
  logic [7:0] sin_rom[8];

  logic [1:0] c_st[32];
  logic [3:0] c_top[32];
  logic [3:0] c_bot[32];
  logic [7:0] c_re[32];
  logic [7:0] c_im[32];

  int total = 0;
  int bad = 0;
  int r_done_n, r_end_n, r_dones, r_vcyc, r_beats;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, 32'(valid), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " stage"}, 32'(stage), 0);
    chk({tag, " top"}, 32'(top_addr), 0);
    chk({tag, " bot"}, 32'(bot_addr), 0);
    chk({tag, " re"}, 32'(tw_re), 0);
    chk({tag, " im"}, 32'(tw_im), 0);
  endtask

  // one transform; optional stall and mid-run start poke
  task automatic run(input logic inv,
                     input int stall_beat,
                     input int stall_len,
                     input int poke_beat);
    int n = 0;
    int beats = 0;
    int stalled = 0;
    bit poked = 0;
    r_done_n = -1;
    r_end_n = -1;
    r_dones = 0;
    r_vcyc = 0;
    @(negedge clk);
    start = 1'b1;
    inverse = inv;
    ready = 1'b1;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      if (n == 1) inverse = ~inv;
      if (done) begin
        r_dones++;
        r_done_n = n;
      end
      if (!busy) begin
        r_end_n = n;
        break;
      end
      if (valid) begin
        r_vcyc++;
        if (beats < 32) begin
          c_st[beats]  = stage;
          c_top[beats] = top_addr;
          c_bot[beats] = bot_addr;
          c_re[beats]  = tw_re;
          c_im[beats]  = tw_im;
        end
        if (beats == stall_beat && stall_len > 0) begin
          chk("hold stage", 32'(stage), 2);
          chk("hold top", 32'(top_addr), 5);
          chk("hold bot", 32'(bot_addr), 7);
          chk("hold re", 32'(tw_re), 32'h00);
          chk("hold im", 32'(tw_im), 32'h81);
        end
        if (beats == stall_beat && stalled < stall_len) begin
          ready = 1'b0;
          stalled++;
        end else begin
          ready = 1'b1;
          beats++;
        end
        if (beats == poke_beat && !poked) begin
          start = 1'b1;
          poked = 1;
        end
      end
    end
    r_beats = beats;
    if (r_end_n < 0) chk("run timeout", 1, 0);
    ready = 1'b0;
  endtask

  task automatic chk_fwd_table(input string tag);
    for (int i = 0; i < 8; i++) begin
      int b;
      b = fwd[i].beat;
      chk({tag, " st"}, 32'(c_st[b]), 32'(fwd[i].st));
      chk({tag, " top"}, 32'(c_top[b]), 32'(fwd[i].top));
      chk({tag, " bot"}, 32'(c_bot[b]), 32'(fwd[i].bot));
      chk({tag, " re"}, 32'(c_re[b]), 32'(fwd[i].re));
      chk({tag, " im"}, 32'(c_im[b]), 32'(fwd[i].im));
    end
    for (int b = 24; b < 32; b++) begin
      chk({tag, " s3 re"}, 32'(c_re[b]), 32'h7F);
      chk({tag, " s3 im"}, 32'(c_im[b]), 32'h00);
      chk({tag, " s3 top"}, 32'(c_top[b]), 32'(2 * (b - 24)));
      chk({tag, " s3 bot"}, 32'(c_bot[b]), 32'(2 * (b - 24) + 1));
    end
  endtask

  initial begin
    int dn;
    fwd[0] = '{0,  2'd0, 4'd0,  4'd8,  8'h7F, 8'h00};
    fwd[1] = '{1,  2'd0, 4'd1,  4'd9,  8'h76, 8'hCF};
    fwd[2] = '{3,  2'd0, 4'd3,  4'd11, 8'h31, 8'h8A};
    fwd[3] = '{4,  2'd0, 4'd4,  4'd12, 8'h00, 8'h81};
    fwd[4] = '{13, 2'd1, 4'd9,  4'd13, 8'h5A, 8'hA6};
    fwd[5] = '{19, 2'd2, 4'd5,  4'd7,  8'h00, 8'h81};
    fwd[6] = '{20, 2'd2, 4'd8,  4'd10, 8'h7F, 8'h00};
    fwd[7] = '{31, 2'd3, 4'd14, 4'd15, 8'h7F, 8'h00};
    inv_v[0] = '{1, 2'd0, 4'd1, 4'd9,  8'h76, 8'h31};
    inv_v[1] = '{4, 2'd0, 4'd4, 4'd12, 8'h00, 8'h7F};
    cos_rom = '{8'h7F, 8'h76, 8'h5A, 8'h31,
                8'h00, 8'hCF, 8'hA6, 8'h8A};
    sin_rom = '{8'h00, 8'h31, 8'h5A, 8'h76,
                8'h7F, 8'h76, 8'h5A, 8'h31};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run(1'b0, -1, 0, -1);
    chk("fwd done cyc", 32'(r_done_n), 33);
    chk("fwd end cyc", 32'(r_end_n), 34);
    chk("fwd dones", 32'(r_dones), 1);
    chk("fwd vcyc", 32'(r_vcyc), 32);
    chk_fwd_table("fwd");

    run(1'b1, -1, 0, -1);
    chk("inv done cyc", 32'(r_done_n), 33);
    for (int i = 0; i < 2; i++) begin
      chk("inv re", 32'(c_re[inv_v[i].beat]), 32'(inv_v[i].re));
      chk("inv im", 32'(c_im[inv_v[i].beat]), 32'(inv_v[i].im));
      chk("inv top", 32'(c_top[inv_v[i].beat]), 32'(inv_v[i].top));
    end
    for (int b = 0; b < 8; b++) begin
      chk("inv s0 re", 32'(c_re[b]), 32'(cos_rom[b]));
      chk("inv s0 im", 32'(c_im[b]), 32'(sin_rom[b]));
    end
    for (int b = 24; b < 32; b++)
      chk("inv s3 re", 32'(c_re[b]), 32'h7F);

    run(1'b0, 19, 3, -1);
    chk("bp vcyc", 32'(r_vcyc), 35);
    chk("bp done cyc", 32'(r_done_n), 36);
    chk("bp dones", 32'(r_dones), 1);
    chk_fwd_table("bp");

    run(1'b0, -1, 0, 10);
    chk("poke done cyc", 32'(r_done_n), 33);
    chk("poke dones", 32'(r_dones), 1);
    chk("poke beats", 32'(r_beats), 32);
    chk_fwd_table("poke");

    @(negedge clk);
    start = 1'b1;
    inverse = 1'b0;
    ready = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("abort pre stage", 32'(stage), 2);
    chk("abort pre top", 32'(top_addr), 1);
    chk("abort pre bot", 32'(bot_addr), 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("abort");
    dn = 0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      if (done || busy || valid) dn++;
    end
    chk("abort quiet", 32'(dn), 0);
    ready = 1'b0;

    run(1'b0, -1, 0, -1);
    chk("restart st", 32'(c_st[0]), 0);
    chk("restart top", 32'(c_top[0]), 0);
    chk("restart bot", 32'(c_bot[0]), 8);
    chk("restart done cyc", 32'(r_done_n), 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
